// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcodes (common with the single-cycle decoder) and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_RTEX   = 4'd6,
    ST_RTWB   = 4'd7,
    ST_IMMEX  = 4'd8,
    ST_IMMWB  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11,
    ST_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Immediate-group ALU instructions that write rt.
  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI);
  endfunction

  // Logical immediates take a zero-extended operand.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational map from FSM state (plus opcode, memory ready and reset)
// to every datapath strobe and mux select.
module mc_ctrl_outputs
  import mips_ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_mem_ready,
  input  logic        i_rst,
  output logic        o_pc_write,
  output logic        o_branch_beq,
  output logic        o_branch_bne,
  output logic [1:0]  o_pc_src,
  output logic        o_iord,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_ir_write,
  output logic        o_reg_write,
  output logic        o_reg_dst,
  output logic        o_memto_reg,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic        o_zero_ext,
  output logic [1:0]  o_alu_op
);

  // Moore decode of the state; reset masks all strobes and parks the
  // selects at their FETCH values.
  always_comb begin
    o_pc_write   = 1'b0;
    o_branch_beq = 1'b0;
    o_branch_bne = 1'b0;
    o_pc_src     = PCSRC_ALU;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_reg_dst    = 1'b0;
    o_memto_reg  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_REG;
    o_zero_ext   = 1'b0;
    o_alu_op     = ALUOP_ADD;
    if (i_rst) begin
      o_alu_src_b = SRCB_FOUR;
    end else begin
      unique case (i_state)
        ST_FETCH: begin
          o_mem_read  = 1'b1;
          o_alu_src_b = SRCB_FOUR;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
        end
        ST_DECODE: o_alu_src_b = SRCB_IMM_SH2;
        ST_MEMADR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = SRCB_IMM;
        end
        ST_MEMRD: begin
          o_iord     = 1'b1;
          o_mem_read = 1'b1;
        end
        ST_MEMWB: begin
          o_reg_write = 1'b1;
          o_memto_reg = 1'b1;
        end
        ST_MEMWR: begin
          o_iord      = 1'b1;
          o_mem_write = 1'b1;
        end
        ST_RTEX: begin
          o_alu_src_a = 1'b1;
          o_alu_op    = ALUOP_FUNCT;
        end
        ST_RTWB: begin
          o_reg_write = 1'b1;
          o_reg_dst   = 1'b1;
        end
        ST_IMMEX: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = SRCB_IMM;
          o_alu_op    = ALUOP_IMM;
          o_zero_ext  = is_logic_imm(i_opcode);
        end
        ST_IMMWB: o_reg_write = 1'b1;
        ST_BRANCH: begin
          o_alu_src_a  = 1'b1;
          o_alu_op     = ALUOP_SUB;
          o_pc_src     = PCSRC_ALUOUT;
          o_branch_beq = (i_opcode == OP_BEQ);
          o_branch_bne = (i_opcode == OP_BNE);
        end
        ST_JUMP: begin
          o_pc_src   = PCSRC_JUMP;
          o_pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencing FSM: state register, next-state logic and
// sticky illegal-opcode flag; output decode lives in mc_ctrl_outputs.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [5:0]  i_opcode,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_branch_beq,
  output logic        o_branch_bne,
  output logic [1:0]  o_pc_src,
  output logic        o_iord,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_ir_write,
  output logic        o_reg_write,
  output logic        o_reg_dst,
  output logic        o_memto_reg,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic        o_zero_ext,
  output logic [1:0]  o_alu_op,
  output logic        o_illegal,
  output logic [3:0]  o_state
);

  state_t r_state;
  state_t w_next;
  logic   r_illegal;

  // State register and sticky illegal flag, set on entry to TRAP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_TRAP) r_illegal <= 1'b1;
    end
  end

  // Next-state selection; memory states stall until i_mem_ready.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FETCH:  if (i_mem_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        if (i_opcode == OP_LW || i_opcode == OP_SW)        w_next = ST_MEMADR;
        else if (i_opcode == OP_RTYPE)                     w_next = ST_RTEX;
        else if (is_imm_op(i_opcode))                      w_next = ST_IMMEX;
        else if (i_opcode == OP_BEQ || i_opcode == OP_BNE) w_next = ST_BRANCH;
        else if (i_opcode == OP_J)                         w_next = ST_JUMP;
        else                                               w_next = ST_TRAP;
      end
      ST_MEMADR: w_next = (i_opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (i_mem_ready) w_next = ST_MEMWB;
      ST_MEMWB:  w_next = ST_FETCH;
      ST_MEMWR:  if (i_mem_ready) w_next = ST_FETCH;
      ST_RTEX:   w_next = ST_RTWB;
      ST_RTWB:   w_next = ST_FETCH;
      ST_IMMEX:  w_next = ST_IMMWB;
      ST_IMMWB:  w_next = ST_FETCH;
      ST_BRANCH: w_next = ST_FETCH;
      ST_JUMP:   w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_TRAP;
    endcase
  end

  assign o_illegal = r_illegal;
  assign o_state   = r_state;

  mc_ctrl_outputs u_outputs (
    .i_state      (r_state),
    .i_opcode     (i_opcode),
    .i_mem_ready  (i_mem_ready),
    .i_rst        (i_rst),
    .o_pc_write   (o_pc_write),
    .o_branch_beq (o_branch_beq),
    .o_branch_bne (o_branch_bne),
    .o_pc_src     (o_pc_src),
    .o_iord       (o_iord),
    .o_mem_read   (o_mem_read),
    .o_mem_write  (o_mem_write),
    .o_ir_write   (o_ir_write),
    .o_reg_write  (o_reg_write),
    .o_reg_dst    (o_reg_dst),
    .o_memto_reg  (o_memto_reg),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_zero_ext   (o_zero_ext),
    .o_alu_op     (o_alu_op)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a vector table of per-cycle
// inputs and hand-computed outputs, plus reset and trap sequences.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch_beq, branch_bne, iord, mem_read, mem_write;
  logic       ir_write, reg_write, reg_dst, memto_reg, alu_src_a, zero_ext;
  logic       illegal;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  multicycle_controller dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_opcode     (opcode),
    .i_mem_ready  (mem_ready),
    .o_pc_write   (pc_write),
    .o_branch_beq (branch_beq),
    .o_branch_bne (branch_bne),
    .o_pc_src     (pc_src),
    .o_iord       (iord),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .o_ir_write   (ir_write),
    .o_reg_write  (reg_write),
    .o_reg_dst    (reg_dst),
    .o_memto_reg  (memto_reg),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_zero_ext   (zero_ext),
    .o_alu_op     (alu_op),
    .o_illegal    (illegal),
    .o_state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pcw beq bne pcsrc[2] iord mrd mwr irw rw rdst m2r srca srcb[2] zext aluop[2] ill
  logic [18:0] act;
  assign act = {pc_write, branch_beq, branch_bne, pc_src, iord, mem_read, mem_write,
                ir_write, reg_write, reg_dst, memto_reg, alu_src_a, alu_src_b,
                zero_ext, alu_op, illegal};

  localparam logic [18:0] E_FETCH_R = 19'b1_0_0_00_0_1_0_1_0_0_0_0_01_0_00_0;
  localparam logic [18:0] E_FETCH_N = 19'b0_0_0_00_0_1_0_0_0_0_0_0_01_0_00_0;
  localparam logic [18:0] E_RESET   = 19'b0_0_0_00_0_0_0_0_0_0_0_0_01_0_00_0;
  localparam logic [18:0] E_DECODE  = 19'b0_0_0_00_0_0_0_0_0_0_0_0_11_0_00_0;
  localparam logic [18:0] E_MEMADR  = 19'b0_0_0_00_0_0_0_0_0_0_0_1_10_0_00_0;
  localparam logic [18:0] E_MEMRD   = 19'b0_0_0_00_1_1_0_0_0_0_0_0_00_0_00_0;
  localparam logic [18:0] E_MEMWB   = 19'b0_0_0_00_0_0_0_0_1_0_1_0_00_0_00_0;
  localparam logic [18:0] E_MEMWR   = 19'b0_0_0_00_1_0_1_0_0_0_0_0_00_0_00_0;
  localparam logic [18:0] E_RTEX    = 19'b0_0_0_00_0_0_0_0_0_0_0_1_00_0_10_0;
  localparam logic [18:0] E_RTWB    = 19'b0_0_0_00_0_0_0_0_1_1_0_0_00_0_00_0;
  localparam logic [18:0] E_IMMEX_S = 19'b0_0_0_00_0_0_0_0_0_0_0_1_10_0_11_0;
  localparam logic [18:0] E_IMMEX_Z = 19'b0_0_0_00_0_0_0_0_0_0_0_1_10_1_11_0;
  localparam logic [18:0] E_IMMWB   = 19'b0_0_0_00_0_0_0_0_1_0_0_0_00_0_00_0;
  localparam logic [18:0] E_BR_BEQ  = 19'b0_1_0_01_0_0_0_0_0_0_0_1_00_0_01_0;
  localparam logic [18:0] E_BR_BNE  = 19'b0_0_1_01_0_0_0_0_0_0_0_1_00_0_01_0;
  localparam logic [18:0] E_JUMP    = 19'b1_0_0_10_0_0_0_0_0_0_0_0_00_0_00_0;
  localparam logic [18:0] E_TRAP    = 19'b0_0_0_00_0_0_0_0_0_0_0_0_00_0_00_1;
  localparam logic [18:0] E_RST_ILL = 19'b0_0_0_00_0_0_0_0_0_0_0_0_01_0_00_1;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, XORI = 6'b001110, JMP = 6'b000010;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [18:0] exp);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, compare outputs mid-cycle, advance one clock.
  task automatic step(input string name, input logic r, input logic [5:0] op,
                      input logic rdy, input logic [3:0] st, input logic [18:0] exp);
    rst = r; opcode = op; mem_ready = rdy;
    #2;
    checks++;
    if (state !== st) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d", name, state, st);
    end
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s outputs: got %b want %b", name, act, exp);
    end
    checks++;
    if ((mem_read && mem_write) || (reg_write && pc_write)) begin
      errors++;
      $display("FAIL %s exclusivity: mrd=%b mwr=%b rw=%b pcw=%b want no overlap",
               name, mem_read, mem_write, reg_write, pc_write);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state (illegal already cleared by earlier reset edges).
    add(1, RT, 1, 4'd0, E_RESET);
    // LW, ready high: 5 cycles.
    add(0, LW, 1, 4'd0, E_FETCH_R);
    add(0, LW, 1, 4'd1, E_DECODE);
    add(0, LW, 1, 4'd2, E_MEMADR);
    add(0, LW, 1, 4'd3, E_MEMRD);
    add(0, LW, 1, 4'd4, E_MEMWB);
    // SW with one FETCH stall and three MEMWR stalls.
    add(0, SW, 0, 4'd0, E_FETCH_N);
    add(0, SW, 1, 4'd0, E_FETCH_R);
    add(0, SW, 1, 4'd1, E_DECODE);
    add(0, SW, 1, 4'd2, E_MEMADR);
    add(0, SW, 0, 4'd5, E_MEMWR);
    add(0, SW, 0, 4'd5, E_MEMWR);
    add(0, SW, 0, 4'd5, E_MEMWR);
    add(0, SW, 1, 4'd5, E_MEMWR);
    // R-type.
    add(0, RT, 1, 4'd0, E_FETCH_R);
    add(0, RT, 0, 4'd1, E_DECODE);
    add(0, RT, 0, 4'd6, E_RTEX);
    add(0, RT, 0, 4'd7, E_RTWB);
    // BNE then BEQ.
    add(0, BNE, 1, 4'd0, E_FETCH_R);
    add(0, BNE, 1, 4'd1, E_DECODE);
    add(0, BNE, 1, 4'd10, E_BR_BNE);
    add(0, BEQ, 1, 4'd0, E_FETCH_R);
    add(0, BEQ, 1, 4'd1, E_DECODE);
    add(0, BEQ, 1, 4'd10, E_BR_BEQ);
    // ORI, ADDI, XORI.
    add(0, ORI, 1, 4'd0, E_FETCH_R);
    add(0, ORI, 1, 4'd1, E_DECODE);
    add(0, ORI, 1, 4'd8, E_IMMEX_Z);
    add(0, ORI, 1, 4'd9, E_IMMWB);
    add(0, ADDI, 1, 4'd0, E_FETCH_R);
    add(0, ADDI, 1, 4'd1, E_DECODE);
    add(0, ADDI, 1, 4'd8, E_IMMEX_S);
    add(0, ADDI, 1, 4'd9, E_IMMWB);
    add(0, XORI, 1, 4'd0, E_FETCH_R);
    add(0, XORI, 1, 4'd1, E_DECODE);
    add(0, XORI, 1, 4'd8, E_IMMEX_Z);
    add(0, XORI, 1, 4'd9, E_IMMWB);
    // J.
    add(0, JMP, 1, 4'd0, E_FETCH_R);
    add(0, JMP, 1, 4'd1, E_DECODE);
    add(0, JMP, 1, 4'd11, E_JUMP);
    add(0, RT, 0, 4'd0, E_FETCH_N);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].rdy,
           vecs[i].st, vecs[i].exp);

    // Reset mid-MEMWR abandons the store.
    step("rw_fetch",  0, SW, 1, 4'd0, E_FETCH_R);
    step("rw_decode", 0, SW, 1, 4'd1, E_DECODE);
    step("rw_memadr", 0, SW, 0, 4'd2, E_MEMADR);
    step("rw_memwr",  0, SW, 0, 4'd5, E_MEMWR);
    step("rw_rst",    1, SW, 0, 4'd5, E_RESET);
    step("rw_after",  0, SW, 0, 4'd0, E_FETCH_N);

    // Unsupported opcode: TRAP absorbs for 20 cycles regardless of inputs.
    step("tr_fetch",  0, 6'b111111, 1, 4'd0, E_FETCH_R);
    step("tr_decode", 0, 6'b111111, 1, 4'd1, E_DECODE);
    for (int k = 0; k < 20; k++)
      step($sformatf("tr_hold%0d", k), 0, (k % 2 == 0) ? LW : 6'b111111,
           k[0], 4'd12, E_TRAP);
    step("tr_rst",   1, RT, 1, 4'd12, E_RST_ILL);
    step("tr_after", 0, RT, 1, 4'd0, E_FETCH_R);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle MIPS core; it replaces the single-cycle opcode decoder when the datapath shares one memory and one ALU across cycles. It steps each instruction through fetch, decode, execute, memory and writeback states and drives every datapath strobe and mux select. It supports R-type, LW, SW, BEQ, BNE, ADDI, SLTI, ANDI, ORI, XORI and J, and waits on a memory-ready handshake.

## Interface
- No parameters; encodings are fixed in the shared package.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  synchronous, active-high reset.
- i_opcode  in  6  instr[31:26], read from the instruction register.
- i_mem_ready  in  1  memory has completed the current read or write this cycle.
- o_pc_write  out  1  unconditional PC load.
- o_branch_beq  out  1  PC load if ALU zero.
- o_branch_bne  out  1  PC load if ALU not zero.
- o_pc_src  out  2  next-PC select: 00 ALU result, 01 ALUOut register, 10 jump target.
- o_iord  out  1  memory address select: 0 PC, 1 ALUOut.
- o_mem_read  out  1  memory read request.
- o_mem_write  out  1  memory write request.
- o_ir_write  out  1  instruction register load.
- o_reg_write  out  1  register file write.
- o_reg_dst  out  1  write destination: 1 rd, 0 rt.
- o_memto_reg  out  1  writeback source: 1 data register, 0 ALUOut.
- o_alu_src_a  out  1  ALU A operand: 0 PC, 1 register A.
- o_alu_src_b  out  2  ALU B operand: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
- o_zero_ext  out  1  zero-extend the immediate (ANDI, ORI, XORI).
- o_alu_op  out  2  ALU operation: 00 add, 01 sub, 10 decode funct, 11 decode opcode (immediate group).
- o_illegal  out  1  sticky: an unsupported opcode was decoded.
- o_state  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, IMMEX, IMMWB, BRANCH, JUMP, TRAP.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write are asserted only when i_mem_ready=1.
  - If i_mem_ready=1, go to DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (computes the branch target into ALUOut). Next state by opcode:
  - LW or SW → MEMADR.
  - 000000 → RTEX.
  - ADDI, SLTI, ANDI, ORI, XORI → IMMEX.
  - BEQ or BNE → BRANCH.
  - J → JUMP.
  - Any other opcode → TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for LW, MEMWR for SW.
  - i_opcode is re-sampled here; the IR is stable because ir_write is 0 outside FETCH.
- MEMRD: iord=1, mem_read=1. Go to MEMWB when i_mem_ready=1.
- MEMWB: reg_write=1, reg_dst=0, memto_reg=1. Go to FETCH.
- MEMWR: iord=1, mem_write=1. Go to FETCH when i_mem_ready=1.
  - mem_write stays high until i_mem_ready is seen.
- RTEX: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RTWB.
- RTWB: reg_write=1, reg_dst=1, memto_reg=0. Go to FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10, alu_op=11. o_zero_ext=1 for ANDI, ORI, XORI. Go to IMMWB.
- IMMWB: reg_write=1, reg_dst=0, memto_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - branch_beq=1 for BEQ, branch_bne=1 for BNE.
  - Go to FETCH.
- JUMP: pc_src=10, pc_write=1. Go to FETCH.
- TRAP: every strobe is 0 and o_illegal=1. TRAP is absorbing; only i_rst leaves it.
- Outputs not listed for a state are 0.

## Timing
- Outputs are Moore, decoded from the state register. The only exceptions are o_pc_write and o_ir_write in FETCH, which are ANDed with i_mem_ready.
- Cycles per instruction with i_mem_ready tied high: LW 5, SW 4, R-type 4, immediate 4, BEQ/BNE 3, J 3.
- Each cycle i_mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Other states ignore i_mem_ready.
- Reset:
  - i_rst=1 at a clock edge loads FETCH and clears o_illegal.
  - While i_rst is high, o_pc_write, o_ir_write, o_mem_write, o_mem_read, o_reg_write, o_branch_beq and o_branch_bne are forced to 0.
  - All select outputs take their FETCH values.
  - Reset in any state, including mid-MEMWR, takes effect on the next edge with no completion of the current instruction.
- Exactly one of o_mem_read and o_mem_write is high in any cycle, or neither; they are never high together.
- o_reg_write and o_pc_write are never high in the same cycle.

## Structure
- Shared package mips_ctrl_pkg holds:
  - the state encodings (4 bits, FETCH=0, TRAP=12);
  - the opcode constants, shared with the single-cycle decoder;
  - the alu_op, pc_src and alu_src_b codes.
- One combinational sub-module, mc_ctrl_outputs, maps state, opcode, i_mem_ready and i_rst to the output controls.
- The state register and next-state logic live in the top module.

## Test plan
- Reset while in MEMWR with mem_write high → the next cycle has o_state=FETCH, mem_write=0 and o_illegal=0.
- LW (opcode 100011), i_mem_ready=1 → the sequence is FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 with memto_reg=1 only in cycle 5.
- SW with i_mem_ready low for 3 cycles in MEMWR → mem_write held high for 4 cycles and FETCH is re-entered after the ready cycle.
- BNE (000101) → BRANCH asserts branch_bne=1, branch_beq=0, alu_op=01, pc_src=01. Total 3 cycles.
- ORI (001101) → IMMEX shows zero_ext=1 and alu_op=11. IMMWB shows reg_dst=0 and reg_write=1. ADDI shows zero_ext=0.
- Opcode 111111 → TRAP after DECODE with o_illegal=1 held for 20 cycles and no strobes; i_rst then gives FETCH.
